bcd_time_adjust_ctrl: RTL and testbench



---
 rtl/bcd_time_adjust_ctrl.sv | 163 ++++++++++++++++
 tb/tb_bcd_time_adjust_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_adjust_ctrl.sv
// bcd_time_adjust_ctrl: key-driven BCD time/date/alarm editor with auto-repeat and load strobes.
// Define ADJ_LEAP_YEAR_EN to give February 29 days in years divisible by 4.
module bcd_time_adjust_ctrl #(
    parameter int NUM_ALARMS   = 2,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000,
    localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode,
    input  logic                    date_time_sel,
    input  logic [1:0]              field_sel,
    input  logic [AW-1:0]           alarm_sel,
    input  logic                    key_up,
    input  logic                    key_down,
    input  logic [23:0]             time_in,
    input  logic [23:0]             date_in,
    output logic [23:0]             adj_time,
    output logic [23:0]             adj_date,
    output logic                    time_load,
    output logic                    date_load,
    output logic [16*NUM_ALARMS-1:0] alarm_bus
);
    localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] C_DLY = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] C_RATE = CW'(REPEAT_RATE);
    localparam int SW = 5 + AW;

    typedef enum logic [1:0] {TRACK, ADJ_TIME, ADJ_DATE, ADJ_ALARM} state_t;

    state_t r_state, w_next;
    logic [23:0] r_time, r_date, w_time_step, w_date_step;
    logic [15:0] r_alarm [NUM_ALARMS];
    logic [15:0] w_alarm_cur, w_alarm_step;
    logic r_time_load, r_date_load;
    logic r_up_q, r_dn_q, r_rep, r_lock;
    logic [CW-1:0] r_cnt, w_cnt_inc;
    logic [SW-1:0] r_sel_q, w_sel;
    logic w_one, w_held, w_fresh, w_hit, w_lock, w_step;
    logic w_alarm_ok;
    logic [AW-1:0] w_alarm_idx;
    logic [7:0] w_mo_new, w_yr_new, w_feb_cur, w_feb_ny, w_dim_mo, w_dim_yr;

    function automatic logic [7:0] bcd_step(input logic [7:0] v, lo, hi, input logic up);
        logic ok;
        ok = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= lo) && (v <= hi);
        return !ok ? lo
             : up ? (v == hi ? lo : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1)
             : (v == lo ? hi : v[3:0] == 4'd0 ? {v[7:4] - 4'd1, 4'd9} : v - 8'd1);
    endfunction

    function automatic logic [7:0] dim(input logic [7:0] mo, input logic [7:0] feb);
        return (mo == 8'h02) ? feb
             : (mo == 8'h04 || mo == 8'h06 || mo == 8'h09 || mo == 8'h11) ? 8'h30 : 8'h31;
    endfunction

    function automatic logic [7:0] clamp(input logic [7:0] d, input logic [7:0] lim);
        return (d > lim) ? lim : d;
    endfunction

`ifdef ADJ_LEAP_YEAR_EN
    // 10*tens mod 4 == 2*tens mod 4, so only the tens parity and the units digit matter
    function automatic logic [7:0] feb_days(input logic [4:0] yr);
        logic leap;
        leap = yr[4] ? (yr[3:0] == 4'd2 || yr[3:0] == 4'd6)
                     : (yr[3:0] == 4'd0 || yr[3:0] == 4'd4 || yr[3:0] == 4'd8);
        return leap ? 8'h29 : 8'h28;
    endfunction
`endif

    always_comb begin
        w_next = (mode == 2'b11) ? (date_time_sel ? ADJ_DATE : ADJ_TIME)
               : (mode == 2'b01) ? ADJ_ALARM : TRACK;
    end

    // Key step generation: press edge, then REPEAT_DELAY, then every REPEAT_RATE
    always_comb begin
        w_sel     = {mode, date_time_sel, field_sel, alarm_sel};
        w_one     = key_up ^ key_down;
        w_held    = key_up ? r_up_q : r_dn_q;
        w_fresh   = w_one & ~w_held;
        w_cnt_inc = r_cnt + 1'b1;
        w_hit     = w_one & w_held & (w_cnt_inc == (r_rep ? C_RATE : C_DLY));
        w_lock    = r_lock | ((w_sel != r_sel_q) & (key_up | key_down));
        w_step    = (w_fresh | w_hit) & ~w_lock;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_up_q  <= 1'b0;
            r_dn_q  <= 1'b0;
            r_sel_q <= '0;
            r_lock  <= 1'b0;
            r_cnt   <= '0;
            r_rep   <= 1'b0;
        end else begin
            r_up_q  <= key_up;
            r_dn_q  <= key_down;
            r_sel_q <= w_sel;
            r_lock  <= w_lock & (key_up | key_down);
            r_cnt   <= (!w_one || w_hit) ? '0 : w_fresh ? CW'(1) : w_cnt_inc;
            r_rep   <= w_one & ~w_fresh & (r_rep | w_hit);
        end
    end

    always_comb begin
        w_mo_new = bcd_step(r_date[15:8], 8'h01, 8'h12, key_up);
        w_yr_new = bcd_step(r_date[23:16], 8'h00, 8'h99, key_up);
`ifdef ADJ_LEAP_YEAR_EN
        w_feb_cur = feb_days(r_date[20:16]);
        w_feb_ny  = feb_days(w_yr_new[4:0]);
`else
        w_feb_cur = 8'h28;
        w_feb_ny  = 8'h28;
`endif
        w_dim_mo = dim(w_mo_new, w_feb_cur);
        w_dim_yr = dim(r_date[15:8], w_feb_ny);
        w_date_step = (field_sel == 2'b00) ? {r_date[23:8], bcd_step(r_date[7:0], 8'h01, dim(r_date[15:8], w_feb_cur), key_up)}
                    : (field_sel == 2'b01) ? {r_date[23:16], w_mo_new, clamp(r_date[7:0], w_dim_mo)}
                    : (field_sel == 2'b10) ? {w_yr_new, r_date[15:8], clamp(r_date[7:0], w_dim_yr)}
                    : r_date;
        w_time_step = (field_sel == 2'b00) ? {r_time[23:8], bcd_step(r_time[7:0], 8'h00, 8'h59, key_up)}
                    : (field_sel == 2'b01) ? {r_time[23:16], bcd_step(r_time[15:8], 8'h00, 8'h59, key_up), r_time[7:0]}
                    : (field_sel == 2'b10) ? {bcd_step(r_time[23:16], 8'h00, 8'h23, key_up), r_time[15:0]}
                    : r_time;
        w_alarm_ok  = {1'b0, alarm_sel} < (AW + 1)'(NUM_ALARMS);
        w_alarm_idx = w_alarm_ok ? alarm_sel : '0;
        w_alarm_cur = r_alarm[w_alarm_idx];
        w_alarm_step = (field_sel == 2'b00) ? {w_alarm_cur[15:8], bcd_step(w_alarm_cur[7:0], 8'h00, 8'h59, key_up)}
                     : (field_sel == 2'b01) ? {bcd_step(w_alarm_cur[15:8], 8'h00, 8'h23, key_up), w_alarm_cur[7:0]}
                     : w_alarm_cur;
    end

    // Each register tracks its live input unless its own edit state is current
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= TRACK;
            r_time      <= 24'h000000;
            r_date      <= 24'h000101;
            r_time_load <= 1'b0;
            r_date_load <= 1'b0;
            for (int k = 0; k < NUM_ALARMS; k++) r_alarm[k] <= 16'h0000;
        end else begin
            r_state     <= w_next;
            r_time_load <= (r_state == ADJ_TIME) && (w_next != ADJ_TIME);
            r_date_load <= (r_state == ADJ_DATE) && (w_next != ADJ_DATE);
            r_time      <= (r_state != ADJ_TIME) ? time_in : w_step ? w_time_step : r_time;
            r_date      <= (r_state != ADJ_DATE) ? date_in : w_step ? w_date_step : r_date;
            if (r_state == ADJ_ALARM && w_step && w_alarm_ok) r_alarm[w_alarm_idx] <= w_alarm_step;
        end
    end

    assign adj_time  = r_time;
    assign adj_date  = r_date;
    assign time_load = r_time_load;
    assign date_load = r_date_load;

    for (genvar k = 0; k < NUM_ALARMS; k++) begin : g_alarm
        assign alarm_bus[16*k +: 16] = r_alarm[k];
    end
endmodule

// File: tb/tb_bcd_time_adjust_ctrl.sv
// tb_bcd_time_adjust_ctrl: directed and randomized checks against a decimal-arithmetic reference model.
module tb_bcd_time_adjust_ctrl;
    localparam int NA = 2;
    localparam int RD = 4;
    localparam int RR = 2;
`ifdef ADJ_LEAP_YEAR_EN
    localparam bit LEAP = 1'b1;
`else
    localparam bit LEAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, dts, key_up, key_down;
    logic [1:0] mode, field_sel;
    logic [0:0] alarm_sel;
    logic [23:0] time_in, date_in, adj_time, adj_date;
    logic time_load, date_load;
    logic [31:0] alarm_bus;

    always #5 clk = ~clk;

    bcd_time_adjust_ctrl #(.NUM_ALARMS(NA), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
        .clk(clk), .rst(rst), .mode(mode), .date_time_sel(dts), .field_sel(field_sel),
        .alarm_sel(alarm_sel), .key_up(key_up), .key_down(key_down), .time_in(time_in),
        .date_in(date_in), .adj_time(adj_time), .adj_date(adj_date), .time_load(time_load),
        .date_load(date_load), .alarm_bus(alarm_bus)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Reference model state
    logic [23:0] m_time, m_date;
    logic [15:0] m_alarm [NA];
    logic m_tl, m_dl, m_lock, m_pu, m_pd;
    logic [5:0] m_sel;
    int m_st, m_h;

    function automatic int dec(input logic [7:0] b);
        return b[7:4] * 10 + b[3:0];
    endfunction

    function automatic logic [7:0] bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [7:0] fstep(input logic [7:0] b, input int lo, input int hi, input bit up);
        int n, x;
        if (b[7:4] > 9 || b[3:0] > 9 || dec(b) < lo || dec(b) > hi) return bcd(lo);
        n = hi - lo + 1;
        x = dec(b) - lo;
        x = up ? (x + 1) % n : (x + n - 1) % n;
        return bcd(lo + x);
    endfunction

    function automatic int mdays(input int mo, input int yr);
        if (mo == 2) return (LEAP && yr % 4 == 0) ? 29 : 28;
        if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
        return 31;
    endfunction

    task automatic model_edge();
        int nx, yr, mo, lim;
        bit one, held, step, up;
        logic [5:0] sel;
        if (rst) begin
            m_time = 24'h000000; m_date = 24'h000101; m_alarm[0] = '0; m_alarm[1] = '0;
            m_tl = 0; m_dl = 0; m_st = 0; m_h = 0; m_lock = 0; m_pu = 0; m_pd = 0; m_sel = '0;
            return;
        end
        sel = {mode, dts, field_sel, alarm_sel};
        one = key_up ^ key_down;
        up = key_up;
        held = key_up ? m_pu : m_pd;
        step = 0;
        if (!one) m_h = 0;
        else if (!held) begin m_h = 1; step = 1; end
        else begin
            m_h++;
            step = (m_h == RD) || (m_h > RD && (m_h - RD) % RR == 0);
        end
        m_lock = (key_up || key_down) && (m_lock || sel != m_sel);
        if (m_lock) step = 0;
        m_sel = sel; m_pu = key_up; m_pd = key_down;
        nx = (mode == 3) ? (dts ? 2 : 1) : (mode == 1) ? 3 : 0;
        m_tl = (m_st == 1 && nx != 1);
        m_dl = (m_st == 2 && nx != 2);
        if (m_st != 1) m_time = time_in;
        else if (step) begin
            case (field_sel)
                2'd0: m_time[7:0]   = fstep(m_time[7:0], 0, 59, up);
                2'd1: m_time[15:8]  = fstep(m_time[15:8], 0, 59, up);
                2'd2: m_time[23:16] = fstep(m_time[23:16], 0, 23, up);
                default: ;
            endcase
        end
        if (m_st != 2) m_date = date_in;
        else if (step && field_sel != 2'd3) begin
            yr = dec(m_date[23:16]);
            mo = dec(m_date[15:8]);
            if (field_sel == 2'd0) m_date[7:0] = fstep(m_date[7:0], 1, mdays(mo, yr), up);
            else begin
                if (field_sel == 2'd1) m_date[15:8] = fstep(m_date[15:8], 1, 12, up);
                else m_date[23:16] = fstep(m_date[23:16], 0, 99, up);
                lim = mdays(dec(m_date[15:8]), dec(m_date[23:16]));
                if (dec(m_date[7:0]) > lim) m_date[7:0] = bcd(lim);
            end
        end
        if (m_st == 3 && step && alarm_sel < NA) begin
            if (field_sel == 2'd0) m_alarm[alarm_sel][7:0] = fstep(m_alarm[alarm_sel][7:0], 0, 59, up);
            if (field_sel == 2'd1) m_alarm[alarm_sel][15:8] = fstep(m_alarm[alarm_sel][15:8], 0, 23, up);
        end
        m_st = nx;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("m_time", {8'h0, adj_time}, {8'h0, m_time});
        check("m_date", {8'h0, adj_date}, {8'h0, m_date});
        check("m_alarm", alarm_bus, {m_alarm[1], m_alarm[0]});
        check("m_tload", {31'h0, time_load}, {31'h0, m_tl});
        check("m_dload", {31'h0, date_load}, {31'h0, m_dl});
    endtask

    function automatic logic [23:0] rnd_time();
        return {bcd($urandom_range(23)), bcd($urandom_range(59)), bcd($urandom_range(59))};
    endfunction

    function automatic logic [23:0] rnd_date();
        return {bcd($urandom_range(99)), bcd($urandom_range(1, 12)), bcd($urandom_range(1, 31))};
    endfunction

    initial begin
        rst = 1; mode = 0; dts = 0; field_sel = 0; alarm_sel = 0; key_up = 0; key_down = 0;
        time_in = 24'h0; date_in = 24'h000101;
        tick(); tick();
        check("rst_time", {8'h0, adj_time}, 32'h0);
        check("rst_date", {8'h0, adj_date}, 32'h000101);
        check("rst_alarm", alarm_bus, 32'h0);
        check("rst_tload", {31'h0, time_load}, 32'h0);
        rst = 0; time_in = 24'h235958; date_in = 24'h240615;
        tick();
        check("track_time", {8'h0, adj_time}, 32'h235958);
        check("track_tload", {31'h0, time_load}, 32'h0);
        mode = 3; dts = 0; field_sel = 2; tick();
        key_up = 1; tick();
        check("hour_wrap", {8'h0, adj_time}, 32'h005958);
        key_up = 0; tick();
        mode = 0; tick();
        check("commit_load", {31'h0, time_load}, 32'h1);
        check("commit_hold", {8'h0, adj_time}, 32'h005958);
        tick();
        check("commit_pulse", {31'h0, time_load}, 32'h0);
        check("commit_track", {8'h0, adj_time}, 32'h235958);
        date_in = 24'h000331; mode = 3; dts = 1; field_sel = 1; tick();
        key_down = 1; tick();
        check("feb_clamp", {8'h0, adj_date}, LEAP ? 32'h000229 : 32'h000228);
        key_down = 0; tick();
        mode = 0; tick();
        check("date_load", {31'h0, date_load}, 32'h1);
        date_in = 24'h010331; tick();
        mode = 3; tick();
        key_down = 1; tick();
        check("feb_nonleap", {8'h0, adj_date}, 32'h010228);
        key_down = 0; tick();
        time_in = 24'h120000; dts = 0; field_sel = 0; tick();
        key_up = 1; tick();
        check("rep_press", {8'h0, adj_time}, 32'h120001);
        repeat (9) tick();
        check("rep_final", {8'h0, adj_time}, 32'h120005);
        key_up = 0; tick();
        field_sel = 1; tick();
        key_up = 1; key_down = 1;
        repeat (20) tick();
        check("both_hold", {8'h0, adj_time}, 32'h120005);
        key_down = 0;
        repeat (3) tick();
        check("both_release", {8'h0, adj_time}, 32'h120005);
        tick();
        check("both_delay", {8'h0, adj_time}, 32'h120105);
        key_up = 0; tick();
        mode = 1; alarm_sel = 1; field_sel = 0; tick();
        key_down = 1; tick();
        check("alarm_dn", alarm_bus, 32'h00590000);
        alarm_sel = 0;
        repeat (8) tick();
        check("alarm_lock", alarm_bus, 32'h00590000);
        key_down = 0; tick();
        key_down = 1; tick();
        check("alarm_relock", alarm_bus, 32'h00590059);
        key_down = 0; tick();
        mode = 0; time_in = 24'h127A00; tick();
        check("illegal_pass", {8'h0, adj_time}, 32'h127A00);
        mode = 3; dts = 0; field_sel = 1; tick();
        key_up = 1; tick();
        check("illegal_min", {8'h0, adj_time}, 32'h120000);
        key_up = 0; tick();
        field_sel = 3; tick();
        key_up = 1; tick();
        check("no_field", {8'h0, adj_time}, 32'h120000);
        key_up = 0; field_sel = 0; tick();
        key_up = 1; tick();
        check("mid_edit", {8'h0, adj_time}, 32'h120001);
        key_up = 0; rst = 1; mode = 0; tick();
        check("rst_mid_time", {8'h0, adj_time}, 32'h0);
        check("rst_mid_load", {31'h0, time_load}, 32'h0);
        rst = 0; tick();
        check("rst_no_strobe", {31'h0, time_load}, 32'h0);
        for (int seg = 0; seg < 300; seg++) begin
            int len, kp;
            mode = 2'($urandom_range(3));
            dts = 1'($urandom_range(1));
            field_sel = 2'($urandom_range(3));
            alarm_sel = 1'($urandom_range(1));
            len = $urandom_range(1, 16);
            kp = $urandom_range(3);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(3) == 0) kp = $urandom_range(3);
                key_up = (kp == 1 || kp == 3);
                key_down = (kp == 2 || kp == 3);
                time_in = rnd_time();
                date_in = rnd_date();
                rst = ($urandom_range(299) == 0);
                tick();
            end
        end
        rst = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
